// File: rtl/fifo_rd_stream_if.sv
// Downstream valid/ready stream bundle used by fifo_rd_stream.
//   o_m_valid : registered downstream valid (driven by master)
//   o_m_data  : registered downstream data  (driven by master)
//   i_m_ready : downstream ready            (driven by slave)
// Member names are written from the point of view of the master block.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  o_m_valid;
  logic [DATA_WIDTH-1:0] o_m_data;
  logic                  i_m_ready;

  modport master (
    output o_m_valid,
    output o_m_data,
    input  i_m_ready
  );

  modport slave (
    input  o_m_valid,
    input  o_m_data,
    output i_m_ready
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a show-ahead FIFO read port into a registered
// valid/ready stream using a main register plus one skid register, so the
// FIFO pop strobe never depends combinationally on downstream ready.
//
// Ports:
//   i_clk           clock, all state on rising edge
//   i_rst           synchronous active-high reset
//   i_fifo_rd_data  show-ahead FIFO data (valid when i_fifo_rd_empty=0)
//   i_fifo_rd_empty FIFO empty flag
//   ow_fifo_read    combinational FIFO pop strobe
//   m_if            downstream stream (master modport: valid/data out, ready in)
//   i_flush         synchronous discard of buffered entries
//   o_occupancy     buffered entry count 0..2
//   o_xfer_count    downstream handshake count
//
// Build option: define FIFO_RD_STREAM_CNT_EN to build the transfer counter;
// otherwise o_xfer_count is tied to 0 and no counter flops exist.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  input  logic                  i_fifo_rd_empty,
  output logic                  ow_fifo_read,
  fifo_rd_stream_if.master      m_if,
  input  logic                  i_flush,
  output logic [1:0]            o_occupancy,
  output logic [CNT_WIDTH-1:0]  o_xfer_count
);

  // Encoding equals the occupancy so the state register drives o_occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;
  logic                  w_pop;
  logic                  w_take;

  // Pop decision uses only registered state and FIFO/control inputs,
  // never i_m_ready, so the FIFO read path stays short.
  assign w_pop  = !i_fifo_rd_empty && !i_rst && !i_flush && (r_state != ST_TWO);
  assign w_take = r_valid && m_if.i_m_ready;

  assign ow_fifo_read   = w_pop;
  assign m_if.o_m_valid = r_valid;
  assign m_if.o_m_data  = r_main;
  assign o_occupancy    = r_state;

  // Buffer state machine
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (i_flush) begin
      // Buffered words are dropped; data registers keep stale contents
      // since r_valid gates them.
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_pop) begin
            r_state <= ST_ONE;
            r_valid <= 1'b1;
            r_main  <= i_fifo_rd_data;
          end
        end
        ST_ONE: begin
          if (w_pop && w_take) begin
            r_main <= i_fifo_rd_data;
          end else if (w_pop) begin
            // Downstream stalled: park the new word behind the main one.
            r_state <= ST_TWO;
            r_skid  <= i_fifo_rd_data;
          end else if (w_take) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (w_take) begin
            r_state <= ST_ONE;
            r_main  <= r_skid;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [CNT_WIDTH-1:0] r_xfer_count;

  // Handshake counter: counts takes even in a flush cycle, wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xfer_count <= '0;
    end else if (w_take) begin
      r_xfer_count <= r_xfer_count + 1'b1;
    end
  end

  assign o_xfer_count = r_xfer_count;
`else
  assign o_xfer_count = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          ow;
  logic          ow4;
  logic          flush;
  logic [1:0]    occ;
  logic [1:0]    occ4;
  logic [15:0]   cnt;
  logic [3:0]    cnt4;

  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();
  fifo_rd_stream_if #(.DATA_WIDTH(DW)) s4_if ();

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_fifo_rd_data(fifo_data),
    .i_fifo_rd_empty(fifo_empty), .ow_fifo_read(ow), .m_if(s_if.master),
    .i_flush(flush), .o_occupancy(occ), .o_xfer_count(cnt)
  );

  // Narrow-counter copy sees identical inputs, so it follows the same
  // transfers and only its counter wrap differs.
  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_fifo_rd_data(fifo_data),
    .i_fifo_rd_empty(fifo_empty), .ow_fifo_read(ow4), .m_if(s4_if.master),
    .i_flush(flush), .o_occupancy(occ4), .o_xfer_count(cnt4)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] rx[$];
  int            n_take;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic set_ready(input logic r);
    s_if.i_m_ready  = r;
    s4_if.i_m_ready = r;
  endtask

  // One clock: sample strobes before the edge, then apply the FIFO pop and
  // record any delivered word as the edge commits it.
  task automatic tick();
    logic rd, tk, rs;
    logic [DW-1:0] d;
    @(negedge clk);
    rd = ow;
    tk = s_if.o_m_valid & s_if.i_m_ready;
    d  = s_if.o_m_data;
    rs = rst;
    @(posedge clk);
    #1;
    if (rs) n_take = 0;
    else if (tk) begin
      n_take++;
      rx.push_back(d);
    end
    if (rd && fifo_q.size() > 0) fifo_q.delete(0);
    drive_fifo();
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    logic [31:0] e16, e4;
`ifdef FIFO_RD_STREAM_CNT_EN
    e16 = n_take & 32'hFFFF;
    e4  = n_take & 32'hF;
`else
    e16 = 0;
    e4  = 0;
`endif
    chk({tag, "_cnt"}, cnt, e16);
    chk({tag, "_cnt4"}, cnt4, e4);
  endtask

  task automatic drain(input string tag, input int budget);
    int b = budget;
    while ((fifo_q.size() > 0 || s_if.o_m_valid) && b > 0) begin
      tick();
      b--;
    end
    chk({tag, "_drained"}, (b > 0) ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; n_take = 0;
    set_ready(1'b1);

    // Reset state and no pop under reset, FIFO pre-loaded
    fifo_q = '{16'h11, 16'h22, 16'h33};
    drive_fifo();
    #1;
    chk("rst_no_pop", ow, 0);
    tick(); tick();
    chk("rst_valid", s_if.o_m_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_data", s_if.o_m_data, 0);
    chk("rst_fifo_untouched", fifo_q.size(), 3);
    chk_cnt("rst");

    // Back-to-back throughput after reset release
    rst = 1'b0;
    #1;
    chk("t1_pop_strobe", ow, 1);
    tick(); chk("t1_w0", s_if.o_m_data, 16'h11); chk("t1_v0", s_if.o_m_valid, 1);
    tick(); chk("t1_w1", s_if.o_m_data, 16'h22); chk("t1_v1", s_if.o_m_valid, 1);
    tick(); chk("t1_w2", s_if.o_m_data, 16'h33); chk("t1_v2", s_if.o_m_valid, 1);
    tick(); chk("t1_idle", s_if.o_m_valid, 0);
    chk("t1_rx_n", rx.size(), 3);
    chk_cnt("t1");

    // Stall fills main+skid only, data holds, then in-order release
    rx.delete();
    set_ready(1'b0);
    fifo_q = '{16'hA1, 16'hA2, 16'hA3, 16'hA4};
    drive_fifo();
    tick(); tick(); tick();
    chk("t2_occ", occ, 2);
    chk("t2_pops", fifo_q.size(), 2);
    chk("t2_no_pop_two", ow, 0);
    chk("t2_hold0", s_if.o_m_data, 16'hA1);
    tick();
    chk("t2_hold1", s_if.o_m_data, 16'hA1);
    set_ready(1'b1);
    drain("t2", 20);
    chk("t2_rx_n", rx.size(), 4);
    for (int i = 0; i < 4 && i < rx.size(); i++)
      chk($sformatf("t2_rx%0d", i), rx[i], 16'hA1 + i);
    chk_cnt("t2");

    // Flush from TWO with downstream stalled
    rx.delete();
    set_ready(1'b0);
    fifo_q = '{16'hB1, 16'hB2, 16'hB3};
    drive_fifo();
    tick(); tick();
    chk("t3_occ2", occ, 2);
    flush = 1'b1;
    #1;
    tick();
    chk("t3_valid", s_if.o_m_valid, 0);
    chk("t3_occ0", occ, 0);
    chk("t3_no_pop_flush", ow, 0);
    flush = 1'b0;
    set_ready(1'b1);
    drain("t3", 10);
    chk("t3_rx_n", rx.size(), 1);
    if (rx.size() > 0) chk("t3_rx0", rx[0], 16'hB3);

    // Flush coinciding with a take still delivers that word
    rx.delete();
    set_ready(1'b0);
    fifo_q = '{16'hD1};
    drive_fifo();
    tick();
    chk("t4_occ1", occ, 1);
    set_ready(1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_valid", s_if.o_m_valid, 0);
    chk("t4_rx_n", rx.size(), 1);
    chk_cnt("t4");

    // Reset while holding one word: discarded, no pop under reset
    rx.delete();
    set_ready(1'b0);
    fifo_q = '{16'hC1, 16'hC2};
    drive_fifo();
    tick();
    chk("t5_occ1", occ, 1);
    rst = 1'b1;
    #1;
    chk("t5_no_pop_rst", ow, 0);
    tick();
    chk("t5_valid", s_if.o_m_valid, 0);
    chk("t5_occ0", occ, 0);
    chk("t5_fifo_kept", fifo_q.size(), 1);
    chk_cnt("t5");
    rst = 1'b0;
    fifo_q.delete();
    drive_fifo();
    #1;

    // 1000 words under random backpressure
    do_reset();
    rx.delete();
    for (int i = 0; i < 1000; i++) fifo_q.push_back(DW'(i));
    drive_fifo();
    begin
      int b = 6000;
      while (rx.size() < 1000 && b > 0) begin
        set_ready(1'($urandom_range(0, 1)));
        tick();
        b--;
      end
    end
    chk("t6_rx_n", rx.size(), 1000);
    for (int i = 0; i < 1000 && i < rx.size(); i++)
      chk($sformatf("t6_rx%0d", i), rx[i], i);
    chk_cnt("t6");
    set_ready(1'b1);
    drain("t6", 10);

    // 17 transfers wrap the 4-bit counter to 1
    do_reset();
    rx.delete();
    for (int i = 0; i < 17; i++) fifo_q.push_back(DW'(16'h100 + i));
    drive_fifo();
    set_ready(1'b1);
    drain("t7", 40);
    chk("t7_rx_n", rx.size(), 17);
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("t7_cnt4_wrap", cnt4, 1);
    chk("t7_cnt16", cnt, 17);
`else
    chk("t7_cnt4_off", cnt4, 0);
    chk("t7_cnt16_off", cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
- REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the data path width in bits.
- REQ-002: Parameter CNT_WIDTH, default 16, SHALL set the transfer counter width in bits.
- REQ-003: i_clk  input  1  SHALL be the single clock for the block; all state updates on its rising edge.
- REQ-004: i_rst  input  1  SHALL be the reset: synchronous, active-high.
- REQ-005: i_fifo_rd_data  input  DATA_WIDTH  SHALL be the show-ahead FIFO read data, valid whenever i_fifo_rd_empty=0.
- REQ-006: i_fifo_rd_empty  input  1  SHALL be the FIFO empty flag.
- REQ-007: ow_fifo_read  output  1  SHALL be the combinational FIFO pop strobe, one entry per asserted cycle.
- REQ-008: o_m_valid  output  1  SHALL be the registered downstream valid.
- REQ-009: o_m_data  output  DATA_WIDTH  SHALL be the registered downstream data.
- REQ-010: i_m_ready  input  1  SHALL be the downstream ready.
- REQ-011: i_flush  input  1  SHALL be a synchronous discard of all buffered entries.
- REQ-012: o_occupancy  output  2  SHALL be the number of buffered entries, 0..2.
- REQ-013: o_xfer_count  output  CNT_WIDTH  SHALL be the downstream handshake count.

Function
- REQ-014: take = o_m_valid & i_m_ready; a word SHALL transfer downstream exactly on cycles where take=1.
- REQ-015: ow_fifo_read SHALL equal !i_fifo_rd_empty & !i_rst & !i_flush & (o_occupancy!=2), with no combinational path from i_m_ready.
- REQ-016: The block SHALL hold a main register (drives o_m_data) and a skid register, with states EMPTY(0), ONE(1), TWO(2) reflected on o_occupancy.
- REQ-017: EMPTY: pop -> ONE, main<=i_fifo_rd_data; else stay.
- REQ-018: ONE: pop&take -> ONE, main<=i_fifo_rd_data; pop&!take -> TWO, skid<=i_fifo_rd_data; !pop&take -> EMPTY; else stay.
- REQ-019: TWO: take -> ONE, main<=skid; else stay. No pop SHALL occur in TWO.
- REQ-020: o_m_valid SHALL be 1 exactly when state is ONE or TWO.
- REQ-021: Latency: a word popped at edge N SHALL appear on o_m_data/o_m_valid immediately after edge N (1 cycle from pop).
- REQ-022: With i_m_ready held 1 and FIFO non-empty, throughput SHALL be one word per cycle.
- REQ-023: While o_m_valid=1 and i_m_ready=0, o_m_data SHALL remain stable.
- REQ-024: Words SHALL be delivered in FIFO order with no loss or duplication.
- REQ-025: i_flush=1 SHALL force state EMPTY at the next edge regardless of pop/take; a take in the same cycle SHALL still count as delivered.
- REQ-026: o_xfer_count SHALL increment by 1 per take, wrapping 2^CNT_WIDTH-1 -> 0; i_flush SHALL NOT clear it.

Reset
- REQ-027: While i_rst=1 at a rising edge: state EMPTY, o_m_valid=0, o_occupancy=0, o_xfer_count=0, ow_fifo_read=0.
- REQ-028: o_m_data and skid SHALL reset to 0.
- REQ-029: Reset mid-transfer SHALL discard buffered words; no FIFO pop SHALL occur in any cycle with i_rst=1.

Configuration
- REQ-030: Macro FIFO_RD_STREAM_CNT_EN defined: o_xfer_count SHALL operate per REQ-026.
- REQ-031: Macro undefined: o_xfer_count SHALL be constant 0 and no counter flops SHALL be synthesized; all other behaviour unchanged.

Verification
- REQ-032: Reset, then FIFO holds 0x11,0x22,0x33, i_m_ready=1 -> o_m_data 0x11,0x22,0x33 on three consecutive cycles, then o_m_valid=0.
- REQ-033: FIFO holds 0xA1..0xA4, i_m_ready=0 -> exactly 2 pops, o_occupancy=2, o_m_data=0xA1 stable; release ready -> 0xA1,0xA2,0xA3,0xA4 in order.
- REQ-034: o_occupancy=2, assert i_flush with i_m_ready=0 -> next cycle o_m_valid=0, o_occupancy=0, ow_fifo_read=0 during flush cycle.
- REQ-035: Random i_m_ready (50%) over 1000 words 0..999 -> downstream sequence 0..999 exact; with CNT_EN o_xfer_count=1000.
- REQ-036: Assert i_rst with o_occupancy=1 -> next cycle o_m_valid=0, o_xfer_count=0, no pop during reset.
- REQ-037: CNT_WIDTH=4, CNT_EN defined, 17 transfers -> o_xfer_count=1.
